// File: rtl/shared_timer_arbiter_pkg.sv
// Shared timer arbiter: state encoding and default sizing.
package shared_timer_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
endpackage

// File: rtl/shared_timer_arbiter_rr_arbiter.sv
// Round-robin pick: first set req bit scanning upward from last+1, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = shared_timer_pkg::DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IW-1:0]      win_idx
);
    // Scan NUM_REQ positions starting just after the last winner; last itself is checked last.
    always_comb begin
        logic          found;
        logic [IW-1:0] i;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        i       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = IW'((int'(last) + k) % NUM_REQ);
            if (!found && req[i]) begin
                found       = 1'b1;
                win_idx     = i;
                win_oh[i]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_timer_arbiter.sv
// One WIDTH-bit counter time-shared among NUM_REQ requesters, granted round-robin.
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] dur,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         count_out
);
    localparam int IW = $clog2(NUM_REQ);

    logic [1:0]         state;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   term;
    logic [IW-1:0]      last;
    logic [IW-1:0]      own;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               cancel;
    logic               term_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req     (req),
        .last    (last),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // term=0 makes term-1 all-ones, giving the full 2**WIDTH-cycle interval.
    assign term_hit  = (count == term - WIDTH'(1));
    assign cancel    = abort || !req[own];
    assign busy      = (state != ST_IDLE);
    assign count_out = count;

    // FSM, counter, latched interval and round-robin pointer.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            term  <= '0;
            last  <= IW'(NUM_REQ - 1);
            own   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req && !abort) begin
                        grant <= win_oh;
                        term  <= dur[win_idx*WIDTH +: WIDTH];
                        count <= '0;
                        last  <= win_idx;
                        own   <= win_idx;
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Cancel beats a coincident terminal count: no done pulse.
                    if (cancel) begin
                        grant <= '0;
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (term_hit) begin
                        done  <= grant;
                        state <= ST_DONE;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    done  <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter (NUM_REQ=4, WIDTH=4).
module tb_shared_timer_arbiter;
    logic        clock;
    logic        reset_L;
    logic [3:0]  req;
    logic [15:0] dur;
    logic        abort;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count_out;

    int n_tests = 0;
    int n_fail  = 0;

    shared_timer_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .req       (req),
        .dur       (dur),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(grant), 0);
        chk({tag, ".done"},  32'(done),  0);
        chk({tag, ".busy"},  32'(busy),  0);
        chk({tag, ".count"}, 32'(count_out), 0);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        chk_idle("reset");
        tick();
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b1;
        req     = '0;
        dur     = '0;
        abort   = 1'b0;
        #1;
        do_reset();

        // Single request, dur=3
        dur[3:0] = 4'd3;
        req      = 4'b0001;
        tick();
        chk("single.grant", 32'(grant), 32'h1);
        chk("single.busy",  32'(busy),  1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("single.cnt%0d", c), 32'(count_out), 32'(c));
            chk("single.nodone", 32'(done), 0);
            tick();
        end
        chk("single.done",  32'(done),  32'h1);
        chk("single.dgnt",  32'(grant), 32'h1);
        chk("single.dcnt",  32'(count_out), 2);
        req = '0;
        tick();
        chk_idle("single.end");

        // Zero duration on requester 2 -> 16 cycles
        dur[11:8] = 4'd0;
        req       = 4'b0100;
        tick();
        chk("zero.grant", 32'(grant), 32'h4);
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("zero.cnt%0d", c), 32'(count_out), 32'(c));
            chk("zero.nodone", 32'(done), 0);
            tick();
        end
        chk("zero.done", 32'(done), 32'h4);
        chk("zero.dcnt", 32'(count_out), 15);
        req = '0;
        tick();
        chk_idle("zero.end");

        // abort in IDLE blocks arbitration for that cycle
        dur[3:0] = 4'd2;
        abort    = 1'b1;
        req      = 4'b0001;
        tick();
        chk("idleabort.grant", 32'(grant), 0);
        abort = 1'b0;
        tick();
        chk("idleabort.grant2", 32'(grant), 32'h1);
        req = '0;
        tick();
        tick();

        // Contention from a fresh pointer: order 0,1,2,3,0
        do_reset();
        dur = 16'h2222;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cont.grant%0d", k), 32'(grant), 32'(1 << (k % 4)));
            tick();
            tick();
            chk($sformatf("cont.done%0d", k), 32'(done), 32'(1 << (k % 4)));
            req[k % 4] = 1'b0;
            tick();
            chk($sformatf("cont.gap%0d", k), 32'(grant), 0);
            req[k % 4] = 1'b1;
        end
        req = '0;
        tick();
        tick();

        // Fairness: req[1] held, req[3] raised during 1's interval
        do_reset();
        dur[7:4] = 4'd4;
        req      = 4'b0010;
        tick();
        chk("fair.grant1", 32'(grant), 32'h2);
        req = 4'b1010;
        tick();
        tick();
        tick();
        tick();
        chk("fair.done1", 32'(done), 32'h2);
        tick();
        chk("fair.gap", 32'(grant), 0);
        tick();
        chk("fair.grant3", 32'(grant), 32'h8);
        req = '0;
        tick();
        tick();

        // Cancel by abort at count 1 of dur=5
        do_reset();
        dur[3:0] = 4'd5;
        req      = 4'b0001;
        tick();
        tick();
        chk("abort.cnt1", 32'(count_out), 1);
        abort = 1'b1;
        tick();
        chk_idle("abort.idle");
        abort = 1'b0;
        req   = '0;
        tick();
        chk("abort.nodone", 32'(done), 0);

        // Cancel by dropping req
        req = 4'b0001;
        tick();
        tick();
        chk("drop.cnt1", 32'(count_out), 1);
        req = '0;
        tick();
        chk_idle("drop.idle");

        // abort coincident with terminal count -> no done
        dur[3:0] = 4'd2;
        req      = 4'b0001;
        tick();
        tick();
        chk("coinc.cnt1", 32'(count_out), 1);
        abort = 1'b1;
        tick();
        chk_idle("coinc.idle");
        abort = 1'b0;
        req   = '0;
        tick();

        // Async reset mid-COUNT, off the clock edge, then pointer reset check
        dur[7:4] = 4'd6;
        req      = 4'b0010;
        tick();
        tick();
        chk("arst.pre", 32'(busy), 1);
        #2;
        reset_L = 1'b0;
        #1;
        chk_idle("arst.now");
        #3;
        reset_L = 1'b1;
        req     = 4'b1010;
        tick();
        chk("arst.grant1", 32'(grant), 32'h2);
        req = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
